// File: rtl/simpleuart_pkg.sv
// Shared types and constants for the simple UART transmitter.
// Covers the FSM state encoding, frame geometry and the divider helper functions.
package simpleuart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam logic [31:0] MIN_DIV    = 32'd2;

  // A bit period shorter than two clocks cannot be counted, so small values are raised to MIN_DIV.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic logic [31:0] write_lanes(input logic [31:0] cur,
                                              input logic [3:0]  we,
                                              input logic [31:0] di);
    logic [31:0] v;
    v = cur;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        v[8*i +: 8] = di[8*i +: 8];
      end else begin
        v[8*i +: 8] = cur[8*i +: 8];
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/simpleuart_tx_fifo.sv
// Byte FIFO that sits in front of the UART transmit FSM.
// Reads are combinational from the head entry, and pushes are ignored when the FIFO is full.
module simpleuart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage array; it has no reset because the level counter decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {LVL_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + {{(LVL_W-1){1'b0}}, 1'b1};
        2'b01:   r_level <= r_level - {{(LVL_W-1){1'b0}}, 1'b1};
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == LVL_W'(DEPTH));
  assign empty = (r_level == {LVL_W{1'b0}});

endmodule

// File: rtl/simpleuart_tx.sv
// Buffered 8N1 UART transmitter with a byte-lane writable baud divider.
// The transmit FSM drains the FIFO and sends each frame immediately after the previous stop bit.
module simpleuart_tx
  import simpleuart_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 104,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    cfg_div_we,
  input  logic [31:0]                   cfg_div_di,
  output logic [31:0]                   cfg_div_do,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [31:0] r_div;
  logic [31:0] r_div_lat;
  logic [31:0] w_div_lat_nxt;
  logic [31:0] r_clk_cnt;
  logic [31:0] w_clk_cnt_nxt;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  w_bit_cnt_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_ser_tx;
  logic        w_ser_nxt;
  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_dout;
  logic [31:0] w_div_eff;
  logic        w_cnt_done;

  assign w_push     = tx_valid && !w_full;
  assign w_div_eff  = clamp_div(r_div);
  assign w_cnt_done = (r_clk_cnt == 32'd0);

  simpleuart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_dout),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  // Divider register with byte-lane writes; the FSM samples it only when a frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= 32'(DEFAULT_DIV);
    end else begin
      r_div <= write_lanes(r_div, cfg_div_we, cfg_div_di);
    end
  end

  // Next-state logic; w_ser_nxt is the line level for the current state, registered one cycle later.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_lat_nxt = r_div_lat;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_ser_nxt     = 1'b1;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        w_ser_nxt = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_dout;
          w_div_lat_nxt = w_div_eff;
          w_clk_cnt_nxt = w_div_eff - 32'd1;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = START;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      START: begin
        w_ser_nxt = 1'b0;
        if (w_cnt_done) begin
          w_clk_cnt_nxt = r_div_lat - 32'd1;
          w_state_nxt   = DATA;
        end else begin
          w_clk_cnt_nxt = r_clk_cnt - 32'd1;
        end
      end
      DATA: begin
        w_ser_nxt = r_shift[0];
        if (w_cnt_done) begin
          w_clk_cnt_nxt = r_div_lat - 32'd1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt - 32'd1;
        end
      end
      STOP: begin
        w_ser_nxt = 1'b1;
        if (w_cnt_done) begin
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_dout;
            w_div_lat_nxt = w_div_eff;
            w_clk_cnt_nxt = w_div_eff - 32'd1;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = START;
          end else begin
            w_state_nxt   = IDLE;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt - 32'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state, counters and the glitch-free line driver; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_div_lat <= 32'(DEFAULT_DIV);
      r_clk_cnt <= 32'd0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_ser_tx  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_div_lat <= w_div_lat_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_ser_tx  <= w_ser_nxt;
    end
  end

  assign ser_tx     = r_ser_tx;
  assign cfg_div_do = r_div;
  assign tx_ready   = !w_full;
  assign busy       = (r_state != IDLE) || !w_empty;

endmodule
